flags_bank: RTL and testbench
=============================

Name: flags_bank

Overview:
- Parametrised multi-channel successor to the single 32-bit flags register.
- Holds CHANNELS configuration words of WIDTH bits each.
- Host writes land in a shadow bank; a commit strobe copies all shadows to the active bank atomically, so capture logic never sees a half-updated configuration.
- finish_now clears a programmable mask of bits in every active word. The block sits between the command decoder and the capture/trigger core.

Parameters:
- WIDTH, 32, bits per flags word.
- CHANNELS, 4, number of flags words (1..16).
- ADDR_W, 2, width of wr_addr; must satisfy 2**ADDR_W >= CHANNELS.
- CLEAR_MASK, 32'h0000_0100, bits cleared in active words by finish_now. Only the low WIDTH bits are used.
- RESET_VALUE, 0, reset value of every shadow and active word (WIDTH bits).

Ports:
- clock, input, 1, sole clock; all state updates on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- wr_en, input, 1, write strobe for the shadow bank.
- wr_addr, input, ADDR_W, shadow word index.
- config_data, input, WIDTH, write data.
- commit, input, 1, copy all shadow words to the active bank.
- finish_now, input, 1, clear CLEAR_MASK bits in all active words.
- flags_reg, output, CHANNELS*WIDTH, active words; word i occupies bits [i*WIDTH +: WIDTH].
- pending, output, 1, high while the shadow holds uncommitted writes.
- commit_done, output, 1, one-cycle pulse the cycle after a commit is applied.
- wr_err, output, 1, one-cycle pulse the cycle after a write to wr_addr >= CHANNELS.

Behaviour:
- Reset (reset_n low at an edge) sets:
  - all shadow and active words = RESET_VALUE
  - pending = 0, commit_done = 0, wr_err = 0
- Reset has priority over every other input.
- Write:
  - wr_en with a valid address loads shadow[wr_addr] = config_data at the edge.
  - pending = 1 from the next cycle.
  - Active words are unchanged.
- Invalid address:
  - wr_en with wr_addr >= CHANNELS changes no state.
  - wr_err = 1 for exactly the next cycle.
  - pending is not set.
- Commit:
  - At the edge with commit = 1, every active word takes its shadow value.
  - flags_reg reflects the new values one cycle after commit is sampled.
  - commit_done pulses high for that one cycle.
  - pending = 0 from the next cycle.
- Commit with no pending writes: the copy still occurs (active = shadow) and commit_done still pulses.
- Write and commit in the same cycle:
  - The write is included (write-through): the active word for wr_addr takes config_data and its shadow takes config_data.
  - pending = 0 afterwards.
- finish_now:
  - At the edge, every active word is ANDed with ~CLEAR_MASK.
  - Shadow words are unaffected, so a later commit restores the shadow value.
- finish_now and commit in the same cycle: the committed value is applied first, then masked. Active = shadow & ~CLEAR_MASK.
- finish_now repeated or held: idempotent.
- No combinational paths from inputs to outputs; all outputs are registered.
- CHANNELS = 1: wr_addr must still be decoded; any nonzero address raises wr_err.

Optional Feature:
- Macro: FLAGS_BANK_READBACK_EN.
- When defined, two extra ports are added:
  - rd_addr, input, ADDR_W.
  - rd_data, output, WIDTH; registered, reset value 0.
- rd_data = shadow[rd_addr] one cycle after rd_addr is sampled.
- A same-cycle write to that address returns the old shadow value.
- rd_addr >= CHANNELS returns 0.
- When undefined, neither port exists and there is no read logic.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles after random activity -> flags_reg = 0, pending = 0, commit_done = 0, wr_err = 0.
- Staged write: write 0x1234_5678 to addr 2, wait 3 cycles -> active word 2 still 0, pending = 1. Pulse commit -> next cycle word 2 = 0x1234_5678, commit_done pulses once, pending = 0.
- Write-through: write 0xA5A5_0100 to addr 1 in the same cycle as commit -> next cycle active word 1 = 0xA5A5_0100, shadow word 1 equal, pending = 0.
- finish_now:
  - With active word 0 = 0x0000_01FF, pulse finish_now -> word 0 = 0x0000_00FF.
  - Then commit -> word 0 = 0x0000_01FF.
  - finish_now and commit together -> word 0 = 0x0000_00FF.
- Invalid address: CHANNELS = 3, write to addr 3 -> wr_err pulses one cycle, no word changes, pending unchanged.
- Readback (FLAGS_BANK_READBACK_EN): write 0xDEAD_BEEF to addr 0, then set rd_addr = 0 -> rd_data = 0xDEAD_BEEF one cycle later. rd_addr = 3 with CHANNELS = 3 -> rd_data = 0.

Source files
------------

// File: rtl/flags_bank.sv
// Double-buffered bank of CHANNELS flags words: host writes stage in a shadow bank and a commit copies all of them to the active bank at once.
// Optional shadow readback port is compiled in with FLAGS_BANK_READBACK_EN.
module flags_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter logic [31:0] CLEAR_MASK  = 32'h0000_0100,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          config_data,
  input  logic                      commit,
  input  logic                      finish_now,
`ifdef FLAGS_BANK_READBACK_EN
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
`endif
  output logic [CHANNELS*WIDTH-1:0] flags_reg,
  output logic                      pending,
  output logic                      commit_done,
  output logic                      wr_err
);

  localparam logic [WIDTH-1:0]  CLR_BITS = WIDTH'(CLEAR_MASK);
  localparam logic [ADDR_W:0]   CH_LIM   = (ADDR_W+1)'(CHANNELS);

  logic [WIDTH-1:0] shadow     [CHANNELS];
  logic [WIDTH-1:0] shadow_nxt [CHANNELS];
  logic [WIDTH-1:0] active     [CHANNELS];
  logic             wr_ok;

  assign wr_ok = ({1'b0, wr_addr} < CH_LIM);

  // Shadow next state; also the source for commit, which gives write-through
  // when a write and a commit land on the same edge.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      shadow_nxt[i] = shadow[i];
      if (wr_en && wr_ok && (wr_addr == ADDR_W'(i)))
        shadow_nxt[i] = config_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow[i] <= RESET_VALUE;
        active[i] <= RESET_VALUE;
      end
      pending     <= 1'b0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow[i] <= shadow_nxt[i];
        // Commit is applied before the finish mask so both together yield shadow & ~mask.
        active[i] <= (commit ? shadow_nxt[i] : active[i]) &
                     (finish_now ? ~CLR_BITS : {WIDTH{1'b1}});
      end
      commit_done <= commit;
      wr_err      <= wr_en && !wr_ok;
      if (commit)
        pending <= 1'b0;
      else if (wr_en && wr_ok)
        pending <= 1'b1;
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
    assign flags_reg[g*WIDTH +: WIDTH] = active[g];
  end

`ifdef FLAGS_BANK_READBACK_EN
  logic [WIDTH-1:0] rd_sel;

  // Addresses beyond CHANNELS match no word and read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(CHANNELS); i++)
      if (rd_addr == ADDR_W'(i))
        rd_sel = shadow[i];
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      rd_data <= '0;
    else
      rd_data <= rd_sel;
  end
`endif

endmodule

// File: tb/tb_flags_bank.sv
// Directed plus randomized bench for flags_bank (3 channels) against a word-level reference model.
module tb_flags_bank;
  localparam int W  = 32;
  localparam int CH = 3;
  localparam int AW = 2;
  localparam logic [31:0] MASK = 32'h0000_0100;

  logic          clock;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  config_data;
  logic          commit;
  logic          finish_now;
  logic [CH*W-1:0] flags_reg;
  logic          pending;
  logic          commit_done;
  logic          wr_err;
`ifdef FLAGS_BANK_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  rd_m;
`endif

  logic [W-1:0] shadow_m [CH];
  logic [W-1:0] active_m [CH];
  logic         pending_m;
  logic         commit_done_m;
  logic         wr_err_m;

  int total = 0;
  int bad   = 0;

  flags_bank #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW), .CLEAR_MASK(MASK), .RESET_VALUE('0)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .config_data(config_data),
    .commit(commit),
    .finish_now(finish_now),
`ifdef FLAGS_BANK_READBACK_EN
    .rd_addr(rd_addr),
    .rd_data(rd_data),
`endif
    .flags_reg(flags_reg),
    .pending(pending),
    .commit_done(commit_done),
    .wr_err(wr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one clock edge expressed as word operations.
  task automatic model_edge();
    bit ok;
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow_m[i] = '0;
        active_m[i] = '0;
      end
      pending_m = 0; commit_done_m = 0; wr_err_m = 0;
`ifdef FLAGS_BANK_READBACK_EN
      rd_m = '0;
`endif
      return;
    end
`ifdef FLAGS_BANK_READBACK_EN
    rd_m = (int'(rd_addr) < CH) ? shadow_m[rd_addr] : '0;
`endif
    ok = int'(wr_addr) < CH;
    commit_done_m = commit;
    wr_err_m = wr_en && !ok;
    if (wr_en && ok) shadow_m[wr_addr] = config_data;
    if (commit) for (int i = 0; i < CH; i++) active_m[i] = shadow_m[i];
    if (finish_now) for (int i = 0; i < CH; i++) active_m[i] = active_m[i] & ~MASK;
    if (commit) pending_m = 0;
    else if (wr_en && ok) pending_m = 1;
  endtask

  task automatic step(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic cm, input logic fn);
    wr_en = we; wr_addr = a; config_data = d; commit = cm; finish_now = fn;
    @(posedge clock);
    model_edge();
    #1;
    wr_en = 0; commit = 0; finish_now = 0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < CH; i++)
      chk($sformatf("%s.word%0d", tag, i), flags_reg[i*W +: W], active_m[i]);
    chk({tag, ".pending"}, W'(pending), W'(pending_m));
    chk({tag, ".commit_done"}, W'(commit_done), W'(commit_done_m));
    chk({tag, ".wr_err"}, W'(wr_err), W'(wr_err_m));
`ifdef FLAGS_BANK_READBACK_EN
    chk({tag, ".rd_data"}, rd_data, rd_m);
`endif
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 0; wr_addr = '0; config_data = '0; commit = 0; finish_now = 0;
`ifdef FLAGS_BANK_READBACK_EN
    rd_addr = '0;
`endif
    idle();
    reset_n = 1'b1;

    // Random activity, then a two-cycle reset.
    for (int i = 0; i < 6; i++)
      step(1'b1, AW'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    idle(); idle();
    reset_n = 1'b1;
    chk("reset.flags", flags_reg[W-1:0] | flags_reg[W +: W] | flags_reg[2*W +: W], '0);
    chk("reset.pending", W'(pending), '0);
    chk("reset.commit_done", W'(commit_done), '0);
    chk("reset.wr_err", W'(wr_err), '0);

    // Staged write stays in the shadow until commit.
    step(1'b1, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    idle(); idle(); idle();
    chk("staged.word2_hold", flags_reg[2*W +: W], 32'h0);
    chk("staged.pending", W'(pending), 32'h1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("staged.word2_commit", flags_reg[2*W +: W], 32'h1234_5678);
    chk("staged.commit_done", W'(commit_done), 32'h1);
    chk("staged.pending_clr", W'(pending), 32'h0);
    idle();
    chk("staged.commit_done_once", W'(commit_done), 32'h0);

    // Write-through: write and commit together.
    step(1'b1, 2'd1, 32'hA5A5_0100, 1'b1, 1'b0);
    chk("wt.word1", flags_reg[W +: W], 32'hA5A5_0100);
    chk("wt.pending", W'(pending), 32'h0);
    check_all("wt");

    // finish_now masking and restore by commit.
    step(1'b1, 2'd0, 32'h0000_01FF, 1'b1, 1'b0);
    chk("fin.setup", flags_reg[W-1:0], 32'h0000_01FF);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("fin.masked", flags_reg[W-1:0], 32'h0000_00FF);
    chk("fin.word1_masked", flags_reg[W +: W], 32'hA5A5_0000);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("fin.idempotent", flags_reg[W-1:0], 32'h0000_00FF);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("fin.restore", flags_reg[W-1:0], 32'h0000_01FF);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    chk("fin.commit_and_finish", flags_reg[W-1:0], 32'h0000_00FF);

    // Invalid address: wr_err pulse only.
    step(1'b1, 2'd1, 32'h0BAD_0001, 1'b0, 1'b0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("inv.wr_err", W'(wr_err), 32'h1);
    chk("inv.pending_kept", W'(pending), 32'h1);
    check_all("inv");
    idle();
    chk("inv.wr_err_once", W'(wr_err), 32'h0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("inv.no_shadow_change", flags_reg[W +: W], 32'h0BAD_0001);
    check_all("inv_commit");

`ifdef FLAGS_BANK_READBACK_EN
    step(1'b1, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rd_addr = 2'd0;
    idle();
    chk("rd.word0", rd_data, 32'hDEAD_BEEF);
    rd_addr = 2'd3;
    idle();
    chk("rd.oob", rd_data, 32'h0);
    rd_addr = 2'd0;
    step(1'b1, 2'd0, 32'h0000_0042, 1'b0, 1'b0);
    chk("rd.old_value", rd_data, 32'hDEAD_BEEF);
`endif

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      reset_n = ($urandom_range(0, 40) != 0);
`ifdef FLAGS_BANK_READBACK_EN
      rd_addr = AW'($urandom_range(0, 3));
`endif
      step(1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
      check_all($sformatf("rnd%0d", n));
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
